// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch win after MAX_STARVE consecutive losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_owner_d;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [BE_W-1:0]   r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_rvalid;
    logic              r_d_rvalid;

    logic w_idle;
    logic w_starved;
    logic w_if_win;
    logic w_d_win;

    assign w_idle    = (r_state == S_IDLE);
    assign w_starved = (r_starve_cnt == SC_W'(MAX_STARVE));
    assign w_if_win  = if_req & (~d_req | w_starved);
    assign w_d_win   = d_req & ~w_if_win;

    // Grants are decided combinationally so the requester sees them in the request cycle.
    assign if_gnt    = rst_n & w_idle & w_if_win;
    assign d_gnt     = rst_n & w_idle & w_d_win;

    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A data win with fetch waiting can only happen below saturation.
                    if (!if_req || w_if_win)
                        r_starve_cnt <= '0;
                    else
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    if (w_if_win) begin
                        r_owner_d  <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= '1;
                        r_mem_addr <= if_addr;
                        r_state    <= S_ISSUE;
                    end else if (w_d_win) begin
                        r_owner_d   <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_be    <= d_be;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_owner_d) begin
                            r_d_rdata  <= mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction table, hand-written corner sequences and random traffic
// checked against a transaction-level arbitration/response model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXS   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] if_addr, d_addr;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_wdata, mem_rdata;
    logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
    logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ifr;
        bit          dr;
        logic [31:0] ia;
        logic [31:0] da;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wd;
        int          gw;
        int          rw;
        logic [31:0] rd;
        bit          spur;
        int          exp_own;
    } vec_t;

    vec_t        tbl[6];
    int          n_chk = 0, n_fail = 0;
    int          losses = 0;
    logic [31:0] last_if = 0, last_d = 0;
    int          gnt_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: fetch wins when alone, or when it has already lost MAXS decisions in a row.
    function automatic int arb(bit ifr, bit dr);
        int own;
        own = (ifr && (!dr || losses >= MAXS)) ? 0 : 1;
        if (!ifr || own == 0) losses = 0;
        else if (losses < MAXS) losses = losses + 1;
        return own;
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_if_gnt"}, if_gnt, 0);      chk({nm, "_d_gnt"}, d_gnt, 0);
        chk({nm, "_if_rvalid"}, if_rvalid, 0); chk({nm, "_d_rvalid"}, d_rvalid, 0);
        chk({nm, "_if_rdata"}, if_rdata, 0);  chk({nm, "_d_rdata"}, d_rdata, 0);
        chk({nm, "_mem_req"}, mem_req, 0);    chk({nm, "_mem_we"}, mem_we, 0);
        chk({nm, "_mem_be"}, mem_be, 0);      chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0); chk({nm, "_busy"}, busy, 0);
    endtask

    // Called in an IDLE cycle just after the rising edge; returns in the following IDLE cycle.
    task automatic run_txn(input vec_t v, input int own);
        logic [31:0] ea;
        logic [3:0]  ebe;
        bit          ewe;
        ea  = own ? v.da : v.ia;
        ewe = own ? v.we : 1'b0;
        ebe = own ? v.be : 4'hF;
        if_req = v.ifr; d_req = v.dr; if_addr = v.ia;
        d_addr = v.da; d_we = v.we; d_be = v.be; d_wdata = v.wd;
        mem_gnt = 0; mem_rvalid = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("if_gnt", if_gnt, own == 0);
        chk("d_gnt", d_gnt, own == 1);
        gnt_cyc = cyc;
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        if_addr = ~v.ia; d_addr = ~v.da; d_wdata = ~v.wd; d_be = ~v.be; d_we = ~v.we;
        chk("starve_cnt", dut.r_starve_cnt, losses);
        for (int w = 0; w <= v.gw; w++) begin
            mem_gnt = (w == v.gw); mem_rvalid = v.spur; mem_rdata = 32'h5A5A_0000 + w;
            @(negedge clk);
            chk("iss_mem_req", mem_req, 1); chk("iss_busy", busy, 1);
            chk("iss_mem_addr", mem_addr, ea); chk("iss_mem_we", mem_we, ewe);
            chk("iss_mem_be", mem_be, ebe);
            if (own == 1) chk("iss_mem_wdata", mem_wdata, v.wd);
            chk("iss_gnts", {if_gnt, d_gnt}, 0);
            chk("iss_rvalid", {if_rvalid, d_rvalid}, 0);
            chk("iss_if_rdata", if_rdata, last_if); chk("iss_d_rdata", d_rdata, last_d);
            @(posedge clk); #1;
        end
        mem_gnt = 0; mem_rvalid = 0;
        for (int w = 0; w < v.rw; w++) begin
            @(negedge clk);
            chk("wait_mem_req", mem_req, 0); chk("wait_busy", busy, 1);
            chk("wait_rvalid", {if_rvalid, d_rvalid}, 0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1; mem_rdata = v.rd;
        @(negedge clk);
        chk("rsp_mem_req", mem_req, 0);
        @(posedge clk); #1;
        mem_rvalid = 0; mem_rdata = $urandom;
        if (own == 1) last_d = v.rd; else last_if = v.rd;
        @(negedge clk);
        chk("resp_if_rvalid", if_rvalid, own == 0);
        chk("resp_d_rvalid", d_rvalid, own == 1);
        chk("resp_if_rdata", if_rdata, last_if);
        chk("resp_d_rdata", d_rdata, last_d);
        chk("resp_busy", busy, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int own, g0;
        vec_t v;
        tbl[0] = '{1, 0, 32'h100, 32'h0,  0, 4'hF, 32'h0,    0, 0, 32'hDEADBEEF, 0, 0};
        tbl[1] = '{0, 1, 32'h0,   32'h20, 1, 4'h3, 32'h1234, 3, 0, 32'hCAFE0001, 0, 1};
        tbl[2] = '{0, 1, 32'h0,   32'h44, 0, 4'hF, 32'h0,    0, 2, 32'h0BADF00D, 0, 1};
        tbl[3] = '{1, 0, 32'h104, 32'h0,  0, 4'hF, 32'h0,    2, 1, 32'h11223344, 1, 0};
        tbl[4] = '{1, 1, 32'h108, 32'h80, 1, 4'hC, 32'hAB00, 0, 0, 32'h00C0FFEE, 0, 1};
        tbl[5] = '{1, 0, 32'h10C, 32'h0,  0, 4'hF, 32'h0,    1, 3, 32'h76543210, 0, 0};

        rst_n = 0; if_req = 1; d_req = 1; if_addr = 0; d_addr = 0; d_we = 0; d_be = 0;
        d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1; if_req = 0; d_req = 0;

        for (int i = 0; i < 6; i++) begin
            own = arb(tbl[i].ifr, tbl[i].dr);
            run_txn(tbl[i], tbl[i].exp_own);
        end

        // Both requesters always present: every fifth grant goes to fetch.
        for (int i = 0; i < 10; i++) begin
            v = '{1, 1, 32'h200 + 4*i, 32'h300 + 4*i, 0, 4'hF, 32'h0, 0, 0, 32'hA0 + i, 0, 0};
            own = arb(1, 1);
            run_txn(v, (i == 4 || i == 9) ? 0 : 1);
        end

        // Response while idle must be dropped.
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        chk("spur_idle_busy2", busy, 0);
        chk("spur_idle_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("spur_idle_if_rdata", if_rdata, last_if);
        chk("spur_idle_d_rdata", d_rdata, last_d);
        @(posedge clk); #1;

        // Back-to-back zero-wait fetches: grants four cycles apart.
        for (int i = 0; i < 3; i++) begin
            v = '{1, 0, 32'h400 + 4*i, 32'h0, 0, 4'hF, 32'h0, 0, 0, 32'hF00D_0000 + i, 0, 0};
            own = arb(1, 0);
            g0 = gnt_cyc;
            run_txn(v, 0);
            if (i > 0) chk("b2b_gnt_spacing", gnt_cyc - g0, 4);
        end

        // Reset while waiting for the response, then a late response.
        if_req = 1; if_addr = 32'h500; mem_gnt = 1;
        @(posedge clk); #1;
        if_req = 0;
        @(posedge clk); #1;
        mem_gnt = 0;
        @(negedge clk);
        chk("rstw_busy_before", busy, 1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk_zero("rstw");
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        chk("rstw_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_if_rdata", if_rdata, 0);
        @(posedge clk); #1;
        losses = 0; last_if = 0; last_d = 0;

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            v.ifr = $urandom_range(1, 0);
            v.dr  = v.ifr ? $urandom_range(1, 0) : 1'b1;
            v.ia  = $urandom; v.da = $urandom; v.we = $urandom_range(1, 0);
            v.be  = $urandom; v.wd = $urandom;
            v.gw  = $urandom_range(3, 0); v.rw = $urandom_range(3, 0);
            v.rd  = $urandom; v.spur = $urandom_range(1, 0); v.exp_own = 0;
            own = arb(v.ifr, v.dr);
            run_txn(v, own);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single memory port between the instruction-fetch stage and the load/store stage. Accepts one request per transaction, issues it to memory, waits for the response and routes it back to the owning stage. Data accesses take priority, with a starvation guard so fetch always makes progress. It sits between the `risky` pipeline front/back ends and the unified memory.

## Interface

Parameters:

- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `MAX_STARVE`, 4, number of consecutive fetch losses after which fetch wins; must be at least 1.

Ports:

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: one-cycle pulse when the fetch request is latched.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out DATA_W: fetch data.
- `d_req` in 1: data request; held with its fields until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in DATA_W/8: byte enables.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: one-cycle pulse when the data request is latched.
- `d_rvalid` out 1: one-cycle pulse on load data or store completion.
- `d_rdata` out DATA_W: load data.
- `mem_req` out 1: memory request; held until `mem_gnt`.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` out: registered copies of the winning request.
- `mem_gnt` in 1: memory accepts the request.
- `mem_rvalid` in 1: memory response; returned for both reads and writes.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation

- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: if any request is present, pick a winner, latch its fields into the `mem_*` registers, record the owner, pulse the owner's `*_gnt` in that same cycle, and go to ISSUE. With no request, stay in IDLE.
- Arbitration:
  - Only `d_req` present: data wins. Only `if_req` present: fetch wins.
  - Both present: data wins unless `starve_cnt == MAX_STARVE`, in which case fetch wins.
  - A fetch request latches address only; `mem_we` = 0 and `mem_be` = all ones.
- `starve_cnt`, width $clog2(MAX_STARVE+1), is updated only in IDLE decision cycles:
  - +1 when data wins while `if_req` = 1.
  - Cleared when fetch wins or when `if_req` = 0.
  - Saturates at MAX_STARVE.
- ISSUE: `mem_req` = 1. On `mem_gnt`, go to WAIT. `mem_rvalid` is ignored in this state.
- WAIT: on `mem_rvalid`, capture `mem_rdata` into the owner's rdata register and go to RESP.
- RESP: the owner's `*_rvalid` = 1 for exactly this cycle, then go to IDLE.
- `d_rvalid` pulses for stores too; `d_rdata` then holds whatever was captured.
- `if_rdata` and `d_rdata` hold their values until the next capture for that owner.
- `mem_rvalid` in IDLE or RESP is dropped; it is a protocol violation and must not alter state.
- Only one transaction is ever outstanding.

## Timing

- Reset, checked at the clock edge while `rst_n` = 0:
  - State goes to IDLE, `starve_cnt` = 0, owner = fetch.
  - All outputs are 0, including the `mem_*` registers and both rdata registers.
- Reset asserted mid-transaction abandons the transaction. No `*_gnt` or `*_rvalid` is produced for it, and any late `mem_rvalid` arriving in IDLE is ignored.
- `*_gnt` and the IDLE→ISSUE transition come from a combinational decision in the request cycle (cycle 0); `mem_req` rises in cycle 1.
- Best-case sequence, with `mem_gnt` in cycle 1 and `mem_rvalid` in cycle 2:
  - `*_rvalid` in cycle 3, IDLE in cycle 4.
  - The next grant is possible in cycle 4, so the minimum is 4 cycles per transaction.
- Response latency = one cycle after `mem_rvalid`. Added latency = `mem_gnt` wait plus memory latency.
- Requesters may drop `*_req` the cycle after `*_gnt`. A `*_req` held past its grant is treated as a new request at the next IDLE.
- Only one `*_gnt` per cycle; `if_gnt` and `d_gnt` are never high together.

## Test plan

- Lone fetch: `if_req` = 1, `if_addr` = 0x100; memory grants in cycle 1 and returns 0xDEADBEEF in cycle 2 → `if_gnt` in cycle 0, `mem_req` with `mem_addr` = 0x100 and `mem_we` = 0 in cycle 1, `if_rvalid` with `if_rdata` = 0xDEADBEEF in cycle 3.
- Store with a stalled memory: `d_we` = 1, `d_be` = 0x3, `d_addr` = 0x20, `d_wdata` = 0x1234; `mem_gnt` held low for 3 cycles → `mem_req` and all fields stable for 4 cycles, `busy` = 1 throughout, `d_rvalid` one cycle after `mem_rvalid`.
- Priority and starvation with MAX_STARVE = 4, `if_req` and `d_req` both held high → grant order D, D, D, D, IF, D, D, D, D, IF; `starve_cnt` reads 0 after each IF grant.
- Spurious response: `mem_rvalid` pulsed in IDLE and in ISSUE → no state change, no `*_rvalid` pulse, no rdata update.
- Reset in WAIT: `rst_n` = 0 for 1 cycle, then `mem_rvalid` arrives → all outputs 0, state IDLE, neither `if_rvalid` nor `d_rvalid` asserts.
- Back-to-back fetches with a 0-wait memory → grants exactly 4 cycles apart; `if_rdata` holds each value until the next capture.
